// File: rtl/mem_access_stage.sv
// Memory-access stage of the Minisys-1A pipeline.
// Holds the EX/MEM and MEM/WB registers and runs the single-port data-memory
// handshake for loads and stores. It covers wait states, a bus timeout and
// alignment exceptions.
module mem_access_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ex_valid,
  input  logic [5:0]  ex_op,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_waddr,
  input  logic        ex_regwrite,
  input  logic        flush,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ex_mem_alu_result,
  output logic        wb_valid,
  output logic        wb_regwrite,
  output logic [4:0]  wb_waddr,
  output logic [31:0] wb_data,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        exc_buserr,
  output logic [31:0] exc_badvaddr
);

  typedef enum logic [1:0] {IDLE, ACCESS, DRAIN} state_t;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state;
  state_t      state_next;
  logic [7:0]  wait_cnt;
  logic [7:0]  wait_cnt_next;

  logic        em_valid;
  logic [5:0]  em_op;
  logic [31:0] em_addr;
  logic [31:0] em_data;
  logic [4:0]  em_waddr;
  logic        em_regwrite;

  logic        is_load;
  logic        is_store;
  logic        is_mem;
  logic        size_byte;
  logic        size_half;
  logic        size_word;
  logic        load_signed;
  logic        misaligned;

  logic        start;
  logic        timed_out;
  logic        complete;
  logic [3:0]  lane_be;
  logic [31:0] store_wdata;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;

  logic        retire_mem;
  logic        retire_plain;
  logic        addr_fault;
  logic        bus_fault;

  // EX/MEM register: reloads whenever the stage is not stalled; a flush drops the incoming slot.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      em_valid    <= 1'b0;
      em_op       <= 6'd0;
      em_addr     <= 32'd0;
      em_data     <= 32'd0;
      em_waddr    <= 5'd0;
      em_regwrite <= 1'b0;
    end else if (!stall) begin
      em_valid    <= ex_valid & ~flush;
      em_op       <= ex_op;
      em_addr     <= ex_alu_result;
      em_data     <= ex_store_data;
      em_waddr    <= ex_waddr;
      em_regwrite <= ex_regwrite;
    end
  end

  // Opcode decode of the held instruction into kind, access size and alignment fault.
  always_comb begin
    is_load     = 1'b0;
    is_store    = 1'b0;
    size_byte   = 1'b0;
    size_half   = 1'b0;
    size_word   = 1'b0;
    load_signed = 1'b0;
    case (em_op)
      OP_LB:  begin is_load  = 1'b1; size_byte = 1'b1; load_signed = 1'b1; end
      OP_LH:  begin is_load  = 1'b1; size_half = 1'b1; load_signed = 1'b1; end
      OP_LW:  begin is_load  = 1'b1; size_word = 1'b1; end
      OP_LBU: begin is_load  = 1'b1; size_byte = 1'b1; end
      OP_LHU: begin is_load  = 1'b1; size_half = 1'b1; end
      OP_SB:  begin is_store = 1'b1; size_byte = 1'b1; end
      OP_SH:  begin is_store = 1'b1; size_half = 1'b1; end
      OP_SW:  begin is_store = 1'b1; size_word = 1'b1; end
      default: ;
    endcase
    is_mem     = is_load | is_store;
    misaligned = (size_half & em_addr[0]) | (size_word & (em_addr[1:0] != 2'b00));
  end

  // Handshake qualifiers. A flush while idle drops the held op before it issues,
  // so a squashed store never reaches memory unless it was already in flight.
  always_comb begin
    start     = (state == IDLE) && em_valid && is_mem && !misaligned && !flush;
    timed_out = (state != IDLE) && (wait_cnt == TIMEOUT_CNT);
  end

  // FSM state and wait-counter register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // FSM next state; the counter restarts on every entry to ACCESS and counts not-ready cycles.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      IDLE: begin
        if (start && !mem_ready) begin
          state_next    = ACCESS;
          wait_cnt_next = 8'd1;
        end else begin
          wait_cnt_next = 8'd0;
        end
      end
      ACCESS: begin
        if (timed_out || mem_ready) begin
          state_next    = IDLE;
          wait_cnt_next = 8'd0;
        end else begin
          state_next    = flush ? DRAIN : ACCESS;
          wait_cnt_next = wait_cnt + 8'd1;
        end
      end
      DRAIN: begin
        if (timed_out || mem_ready) begin
          state_next    = IDLE;
          wait_cnt_next = 8'd0;
        end else begin
          wait_cnt_next = wait_cnt + 8'd1;
        end
      end
      default: begin
        state_next    = IDLE;
        wait_cnt_next = 8'd0;
      end
    endcase
  end

  // FSM outputs: the request is combinational from IDLE so zero-wait memory costs no stall.
  always_comb begin
    mem_req   = start || ((state != IDLE) && !timed_out);
    stall     = mem_req && !mem_ready;
    complete  = mem_req && mem_ready;
    mem_we    = mem_req && is_store;
    mem_be    = mem_req ? lane_be : 4'b0000;
    mem_addr  = {em_addr[31:2], 2'b00};
    mem_wdata = store_wdata;
  end

  // Little-endian byte-lane enables and lane-replicated store data.
  always_comb begin
    lane_be     = 4'b1111;
    store_wdata = em_data;
    if (is_store && size_byte) begin
      lane_be     = 4'b0001 << em_addr[1:0];
      store_wdata = {4{em_data[7:0]}};
    end else if (is_store && size_half) begin
      lane_be     = em_addr[1] ? 4'b1100 : 4'b0011;
      store_wdata = {2{em_data[15:0]}};
    end
  end

  // Load extraction: select the addressed byte or halfword and extend it.
  always_comb begin
    load_byte = mem_rdata[{em_addr[1:0], 3'b000} +: 8];
    load_half = em_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data = mem_rdata;
    if (size_byte) begin
      load_data = load_signed ? {{24{load_byte[7]}}, load_byte} : {24'd0, load_byte};
    end else if (size_half) begin
      load_data = load_signed ? {{16{load_half[15]}}, load_half} : {16'd0, load_half};
    end
  end

  // Retirement qualifiers: DRAIN completions and anything flushed leave no trace in MEM/WB.
  always_comb begin
    retire_mem   = complete && (state != DRAIN) && !flush;
    retire_plain = (state == IDLE) && em_valid && !is_mem && !flush;
    addr_fault   = (state == IDLE) && em_valid && is_mem && misaligned && !flush;
    bus_fault    = (state == ACCESS) && timed_out && !flush;
  end

  // MEM/WB register with one-cycle exception flags; data fields hold when nothing retires.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid     <= 1'b0;
      wb_regwrite  <= 1'b0;
      wb_waddr     <= 5'd0;
      wb_data      <= 32'd0;
      exc_adel     <= 1'b0;
      exc_ades     <= 1'b0;
      exc_buserr   <= 1'b0;
      exc_badvaddr <= 32'd0;
    end else begin
      wb_valid    <= retire_mem | retire_plain | addr_fault;
      wb_regwrite <= (retire_mem & is_load & em_regwrite) | (retire_plain & em_regwrite);
      exc_adel    <= addr_fault & is_load;
      exc_ades    <= addr_fault & is_store;
      exc_buserr  <= bus_fault;
      if (retire_mem || retire_plain || addr_fault) begin
        wb_waddr <= em_waddr;
      end
      if (retire_mem || retire_plain) begin
        wb_data <= (retire_mem && is_load) ? load_data : em_addr;
      end
      if (addr_fault || bus_fault) begin
        exc_badvaddr <= em_addr;
      end
    end
  end

  assign ex_mem_alu_result = em_addr;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage with a write-back scoreboard.
module tb_mem_access_stage;

  localparam logic [5:0] OP_ADD = 6'b000000;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ex_valid;
  logic [5:0]  ex_op;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_waddr;
  logic        ex_regwrite;
  logic        flush;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] ex_mem_alu_result;
  logic        wb_valid;
  logic        wb_regwrite;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_data;
  logic        exc_adel;
  logic        exc_ades;
  logic        exc_buserr;
  logic [31:0] exc_badvaddr;

  typedef struct {
    logic [4:0]  waddr;
    logic [31:0] data;
    logic        regwrite;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  mem_access_stage #(.TIMEOUT(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .ex_valid(ex_valid), .ex_op(ex_op), .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data), .ex_waddr(ex_waddr), .ex_regwrite(ex_regwrite),
    .flush(flush), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .ex_mem_alu_result(ex_mem_alu_result),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_waddr(wb_waddr), .wb_data(wb_data),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .exc_buserr(exc_buserr),
    .exc_badvaddr(exc_badvaddr)
  );

  always #5 clock = ~clock;

  // Reference load extraction, written from the little-endian lane rules.
  function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    logic [31:0] b;
    logic [31:0] h;
    b = rdata >> (8 * int'(addr[1:0]));
    h = addr[1] ? (rdata >> 16) : rdata;
    case (op)
      OP_LB:   return {{24{b[7]}}, b[7:0]};
      OP_LBU:  return {24'd0, b[7:0]};
      OP_LH:   return {{16{h[15]}}, h[15:0]};
      OP_LHU:  return {16'd0, h[15:0]};
      default: return rdata;
    endcase
  endfunction

  task automatic drive_ex(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data,
                          input logic [4:0] waddr, input logic rw);
    ex_op = op; ex_alu_result = addr; ex_store_data = data; ex_waddr = waddr; ex_regwrite = rw;
    ex_valid = 1'b1;
    @(posedge clock); #1;
    ex_valid = 1'b0;
  endtask

  // Memory responder: raises ready after 'waits' request cycles; bounded so it cannot hang.
  task automatic mem_cycle(input int waits, input logic [31:0] rdata,
                           output int req_cycles, output int stall_cycles);
    logic ready_now;
    req_cycles = 0;
    stall_cycles = 0;
    for (int i = 0; i < 300; i++) begin
      mem_rdata = rdata;
      mem_ready = (i >= waits);
      #1;
      if (!mem_req) begin
        mem_ready = 1'b0;
        break;
      end
      req_cycles++;
      if (stall) stall_cycles++;
      ready_now = mem_ready;
      @(posedge clock); #1;
      mem_ready = 1'b0;
      if (ready_now) break;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ex_valid = 1'b0; ex_op = '0; ex_alu_result = '0; ex_store_data = '0;
    ex_waddr = '0; ex_regwrite = 1'b0; flush = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    #12;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mem_req got %b want 0", mem_req); end
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_stall got %b want 0", stall); end
    vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wb_valid got %b want 0", wb_valid); end
    vectors++; if (wb_data !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_wb_data got %h want 0", wb_data); end
    vectors++; if ({exc_adel, exc_ades, exc_buserr} !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_exc got %b want 000", {exc_adel, exc_ades, exc_buserr}); end
    vectors++; if (mem_be !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_mem_be got %b want 0000", mem_be); end
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_load_word();
    exp_t e;
    int rc, sc;
    sb_q.push_back('{waddr: 5'd3, data: 32'hDEADBEEF, regwrite: 1'b1});
    drive_ex(OP_LW, 32'h100, 32'h0, 5'd3, 1'b1);
    vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("[TB] FAIL lw_req got %b want 1", mem_req); end
    vectors++; if (mem_addr !== 32'h100) begin miscompares++; $display("[TB] FAIL lw_addr got %h want 100", mem_addr); end
    vectors++; if ({mem_we, mem_be} !== 5'b01111) begin miscompares++; $display("[TB] FAIL lw_we_be got %b want 01111", {mem_we, mem_be}); end
    vectors++; if (ex_mem_alu_result !== 32'h100) begin miscompares++; $display("[TB] FAIL lw_fwd got %h want 100", ex_mem_alu_result); end
    mem_cycle(0, 32'hDEADBEEF, rc, sc);
    vectors++; if (sc !== 0 || rc !== 1) begin miscompares++; $display("[TB] FAIL lw_stall got stall=%0d req=%0d want 0/1", sc, rc); end
    e = sb_q.pop_front();
    vectors++; if (wb_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL lw_wb_valid got %b want 1", wb_valid); end
    vectors++; if (wb_data !== e.data) begin miscompares++; $display("[TB] FAIL lw_wb_data got %h want %h", wb_data, e.data); end
    vectors++; if ({wb_regwrite, wb_waddr} !== {e.regwrite, e.waddr}) begin miscompares++; $display("[TB] FAIL lw_wb_rw got %b/%0d want %b/%0d", wb_regwrite, wb_waddr, e.regwrite, e.waddr); end
  endtask

  task automatic test_sub_word_loads();
    logic [5:0]  ops   [5] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LB};
    logic [31:0] addrs [5] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h100};
    logic [31:0] rd    [5] = '{32'h80FFFFFF, 32'h80FFFFFF, 32'h80011234, 32'h80019234, 32'h0000007F};
    int          waits [5] = '{3, 1, 0, 2, 0};
    exp_t e;
    int rc, sc;
    for (int i = 0; i < 5; i++) begin
      sb_q.push_back('{waddr: 5'(i + 10), data: model_load(ops[i], addrs[i], rd[i]), regwrite: 1'b1});
      drive_ex(ops[i], addrs[i], 32'h0, 5'(i + 10), 1'b1);
      mem_cycle(waits[i], rd[i], rc, sc);
      vectors++; if (sc !== waits[i]) begin miscompares++; $display("[TB] FAIL load%0d_stall got %0d want %0d", i, sc, waits[i]); end
      e = sb_q.pop_front();
      vectors++; if (wb_data !== e.data || wb_regwrite !== e.regwrite) begin miscompares++; $display("[TB] FAIL load%0d_wb got %h/%b want %h/%b", i, wb_data, wb_regwrite, e.data, e.regwrite); end
    end
  endtask

  task automatic test_stores();
    logic [5:0]  ops   [3] = '{OP_SB, OP_SH, OP_SW};
    logic [31:0] addrs [3] = '{32'h202, 32'h206, 32'h20C};
    logic [31:0] data  [3] = '{32'h000000AB, 32'h00001234, 32'h11223344};
    logic [3:0]  be    [3] = '{4'b0100, 4'b1100, 4'b1111};
    logic [31:0] wd    [3] = '{32'hABABABAB, 32'h12341234, 32'h11223344};
    logic [31:0] ma    [3] = '{32'h200, 32'h204, 32'h20C};
    exp_t e;
    int rc, sc;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back('{waddr: 5'd0, data: 32'h0, regwrite: 1'b0});
      drive_ex(ops[i], addrs[i], data[i], 5'd0, 1'b0);
      vectors++; if ({mem_req, mem_we, mem_be} !== {2'b11, be[i]}) begin miscompares++; $display("[TB] FAIL st%0d_req_we_be got %b want %b", i, {mem_req, mem_we, mem_be}, {2'b11, be[i]}); end
      vectors++; if (mem_wdata !== wd[i] || mem_addr !== ma[i]) begin miscompares++; $display("[TB] FAIL st%0d_data_addr got %h/%h want %h/%h", i, mem_wdata, mem_addr, wd[i], ma[i]); end
      mem_cycle(1, 32'h0, rc, sc);
      e = sb_q.pop_front();
      vectors++; if (wb_valid !== 1'b1 || wb_regwrite !== e.regwrite) begin miscompares++; $display("[TB] FAIL st%0d_wb got %b/%b want 1/%b", i, wb_valid, wb_regwrite, e.regwrite); end
    end
  endtask

  task automatic test_misaligned();
    logic [5:0]  ops   [4] = '{OP_SH, OP_LW, OP_LH, OP_SW};
    logic [31:0] addrs [4] = '{32'h301, 32'h302, 32'h101, 32'h303};
    logic [1:0]  exc   [4] = '{2'b01, 2'b10, 2'b10, 2'b01};
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b0;
      drive_ex(ops[i], addrs[i], 32'h5555, 5'd7, 1'b1);
      vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL mis%0d_req got %b want 0", i, mem_req); end
      @(posedge clock); #1;
      vectors++; if ({exc_adel, exc_ades} !== exc[i] || exc_badvaddr !== addrs[i]) begin miscompares++; $display("[TB] FAIL mis%0d_exc got %b/%h want %b/%h", i, {exc_adel, exc_ades}, exc_badvaddr, exc[i], addrs[i]); end
      vectors++; if (wb_regwrite !== 1'b0) begin miscompares++; $display("[TB] FAIL mis%0d_regwrite got %b want 0", i, wb_regwrite); end
      @(posedge clock); #1;
      vectors++; if ({exc_adel, exc_ades} !== 2'b00) begin miscompares++; $display("[TB] FAIL mis%0d_pulse got %b want 00", i, {exc_adel, exc_ades}); end
    end
  endtask

  task automatic test_non_mem();
    exp_t e;
    sb_q.push_back('{waddr: 5'd9, data: 32'h12345678, regwrite: 1'b1});
    drive_ex(OP_ADD, 32'h12345678, 32'h0, 5'd9, 1'b1);
    vectors++; if ({mem_req, stall} !== 2'b00) begin miscompares++; $display("[TB] FAIL alu_req_stall got %b want 00", {mem_req, stall}); end
    @(posedge clock); #1;
    e = sb_q.pop_front();
    vectors++; if (wb_data !== e.data || wb_regwrite !== e.regwrite || wb_waddr !== e.waddr) begin miscompares++; $display("[TB] FAIL alu_wb got %h/%b/%0d want %h/%b/%0d", wb_data, wb_regwrite, wb_waddr, e.data, e.regwrite, e.waddr); end
  endtask

  task automatic test_timeout();
    int rc, sc;
    drive_ex(OP_LW, 32'h400, 32'h0, 5'd4, 1'b1);
    mem_cycle(1000, 32'h0, rc, sc);
    vectors++; if (rc !== 4 || sc !== 4) begin miscompares++; $display("[TB] FAIL tmo_cycles got req=%0d stall=%0d want 4/4", rc, sc); end
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL tmo_req_drop got %b want 0", mem_req); end
    @(posedge clock); #1;
    vectors++; if (exc_buserr !== 1'b1 || exc_badvaddr !== 32'h400) begin miscompares++; $display("[TB] FAIL tmo_buserr got %b/%h want 1/400", exc_buserr, exc_badvaddr); end
    vectors++; if ({wb_valid, wb_regwrite} !== 2'b00) begin miscompares++; $display("[TB] FAIL tmo_wb got %b want 00", {wb_valid, wb_regwrite}); end
    @(posedge clock); #1;
    vectors++; if (exc_buserr !== 1'b0) begin miscompares++; $display("[TB] FAIL tmo_pulse got %b want 0", exc_buserr); end
  endtask

  task automatic test_flush();
    mem_ready = 1'b0;
    drive_ex(OP_LW, 32'h110, 32'h0, 5'd5, 1'b1);
    @(posedge clock); #1;
    flush = 1'b1; #1;
    vectors++; if ({mem_req, stall} !== 2'b11) begin miscompares++; $display("[TB] FAIL fl_wait got %b want 11", {mem_req, stall}); end
    @(posedge clock); #1;
    flush = 1'b0;
    vectors++; if ({mem_req, stall} !== 2'b11 || mem_addr !== 32'h110) begin miscompares++; $display("[TB] FAIL fl_drain got %b/%h want 11/110", {mem_req, stall}, mem_addr); end
    @(posedge clock); #1;
    mem_ready = 1'b1; mem_rdata = 32'h13572468; #1;
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL fl_release got %b want 0", stall); end
    @(posedge clock); #1;
    mem_ready = 1'b0;
    vectors++; if ({wb_valid, wb_regwrite, mem_req} !== 3'b000) begin miscompares++; $display("[TB] FAIL fl_no_wb got %b want 000", {wb_valid, wb_regwrite, mem_req}); end
    drive_ex(OP_LW, 32'h124, 32'h0, 5'd6, 1'b1);
    @(posedge clock); #1;
    flush = 1'b1; mem_ready = 1'b1; #1;
    vectors++; if ({mem_req, stall} !== 2'b10) begin miscompares++; $display("[TB] FAIL fl_ready_same got %b want 10", {mem_req, stall}); end
    @(posedge clock); #1;
    flush = 1'b0; mem_ready = 1'b0;
    vectors++; if ({wb_valid, wb_regwrite, mem_req} !== 3'b000) begin miscompares++; $display("[TB] FAIL fl_ready_wb got %b want 000", {wb_valid, wb_regwrite, mem_req}); end
  endtask

  task automatic test_reset_mid_access();
    mem_ready = 1'b0;
    drive_ex(OP_LW, 32'h140, 32'h0, 5'd8, 1'b1);
    @(posedge clock); #1;
    reset_n = 1'b0; #1;
    vectors++; if ({mem_req, stall} !== 2'b00) begin miscompares++; $display("[TB] FAIL rst_mid got %b want 00", {mem_req, stall}); end
    #2 reset_n = 1'b1;
    @(posedge clock); #1;
    vectors++; if ({mem_req, wb_valid} !== 2'b00) begin miscompares++; $display("[TB] FAIL rst_after got %b want 00", {mem_req, wb_valid}); end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  ops   [6] = '{OP_ADD, OP_LW, OP_SW, OP_LBU, OP_LH, OP_ADD};
    logic [31:0] addrs [6] = '{32'h55, 32'h40, 32'h44, 32'h41, 32'h42, 32'h77};
    logic        rws   [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] rd;
    logic        stall_seen;
    exp_t e;
    rd = 32'hCAFEF00D;
    mem_rdata = rd; mem_ready = 1'b1;
    stall_seen = 1'b0;
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) begin
        ex_op = ops[i]; ex_alu_result = addrs[i]; ex_store_data = 32'h99;
        ex_waddr = 5'(i + 20); ex_regwrite = rws[i]; ex_valid = 1'b1;
        sb_q.push_back('{waddr: 5'(i + 20), regwrite: rws[i],
                         data: (ops[i] == OP_ADD) ? addrs[i] : model_load(ops[i], addrs[i], rd)});
      end else begin
        ex_valid = 1'b0;
      end
      @(posedge clock); #1;
      stall_seen = stall_seen | stall;
      if (i > 0) begin
        e = sb_q.pop_front();
        vectors++; if (wb_valid !== 1'b1 || wb_regwrite !== e.regwrite || wb_waddr !== e.waddr) begin miscompares++; $display("[TB] FAIL b2b%0d_ctl got %b/%b/%0d want 1/%b/%0d", i - 1, wb_valid, wb_regwrite, wb_waddr, e.regwrite, e.waddr); end
        if (e.regwrite) begin
          vectors++; if (wb_data !== e.data) begin miscompares++; $display("[TB] FAIL b2b%0d_data got %h want %h", i - 1, wb_data, e.data); end
        end
      end
    end
    mem_ready = 1'b0;
    vectors++; if (stall_seen !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_stall got %b want 0", stall_seen); end
  endtask

  // Hard stop if the sequence ever wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  // Test sequence.
  initial begin
    test_reset();
    test_load_word();
    test_sub_word_loads();
    test_stores();
    test_misaligned();
    test_non_mem();
    test_timeout();
    test_flush();
    test_reset_mid_access();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
